// File: rtl/axil_gpio_master.sv
// AXI4-Lite initiator for the PL GPIO register slave (9-bit address, 32-bit data).
// Turns single-beat fabric read/write commands into AXI4-Lite transactions, one at a time.
//
// Ports:
//   clk100, rst          - clock (rising edge) and synchronous active-high reset
//   cmd_*                - command request: valid/ready, write flag, address, data, strobes
//   rsp_*                - response: valid/ready, read data (0 for writes), BRESP/RRESP
//   busy_o               - high whenever a command is in flight or its response is pending
//   timeout_o            - sticky watchdog flag, cleared by the next command accept or rst
//   m_axi_aw*/w*/b*      - AXI4-Lite write address, write data and write response channels
//   m_axi_ar*/r*         - AXI4-Lite read address and read data channels
//
// TIMEOUT_CYCLES: cycles spent waiting on AXI before timeout_o sets; 0 disables the watchdog.
// All outputs come straight from registers.
module axil_gpio_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [8:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [8:0]  m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [8:0]  m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StRsp
    } state_e;

    localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_CYCLES);
    localparam bit          WdEnable     = (TIMEOUT_CYCLES != 0);

    state_e      state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;

    logic cmd_accept;
    logic aw_done;
    logic w_done;
    logic wait_state;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;

        cmd_accept = cmd_valid && cmd_ready_q;
        // A channel counts as done once its valid has dropped or it handshakes this cycle.
        aw_done    = !awvalid_q || m_axi_awready;
        w_done     = !wvalid_q || m_axi_wready;
        wait_state = (state_q == StWrReq) || (state_q == StWrResp) ||
                     (state_q == StRdReq) || (state_q == StRdData);

        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (cmd_write) begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrReq: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (m_axi_bvalid) begin
                    state_d     = StRsp;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = 32'h0;
                    resp_d      = m_axi_bresp;
                end
            end
            StRdReq: begin
                if (m_axi_arready) begin
                    state_d   = StRdData;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdData: begin
                if (m_axi_rvalid) begin
                    state_d     = StRsp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = m_axi_rdata;
                    resp_d      = m_axi_rresp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Watchdog only flags a stalled slave; the transaction itself keeps waiting.
        if (cmd_accept) begin
            wd_cnt_d  = 32'h0;
            timeout_d = 1'b0;
        end else if (WdEnable && wait_state && (wd_cnt_q != TimeoutLimit)) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
            if ((wd_cnt_q + 32'd1) == TimeoutLimit) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= 9'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            resp_q      <= 2'b00;
            wd_cnt_q    <= 32'h0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_gpio_master.sv
// Bench for axil_gpio_master: a configurable AXI-Lite slave, a transaction-level model of
// the master, a per-cycle compare process and directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_axil_gpio_master;

    localparam int TO = 16;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [8:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy_o, timeout_o;
    logic [8:0]  m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    axil_gpio_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk100(clk100), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy_o(busy_o), .timeout_o(timeout_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Slave configuration, set by the scenarios.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
    bit          aw_block = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    int          b_count = 0;

    // AXI-Lite slave: drives its outputs on the falling edge, detects handshakes one cycle late.
    initial begin
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit p_awv, p_wv, p_bready, p_arv, p_rready, aw_got, w_got, b_pend, r_pend;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b11;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 32'hBAD0_BAD0; m_axi_rresp = 2'b11;
        {p_awv, p_wv, p_bready, p_arv, p_rready, aw_got, w_got, b_pend, r_pend} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        forever begin
            @(negedge clk100);
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
                m_axi_rvalid = 0;
                {p_awv, p_wv, p_bready, p_arv, p_rready, aw_got, w_got, b_pend, r_pend} = '0;
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
            end else begin
                aw_hs = p_awv && m_axi_awready;
                w_hs  = p_wv && m_axi_wready;
                b_hs  = m_axi_bvalid && p_bready;
                ar_hs = p_arv && m_axi_arready;
                r_hs  = m_axi_rvalid && p_rready;
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (b_hs) begin m_axi_bvalid = 0; m_axi_bresp = 2'b11; b_count++; end
                if (r_hs) begin m_axi_rvalid = 0; m_axi_rdata = 32'hBAD0_BAD0; m_axi_rresp = 2'b11; end
                if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
                if (ar_hs) begin r_pend = 1; r_cnt = 0; end
                if (b_pend) begin
                    if (b_cnt >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; b_pend = 0; end
                    else b_cnt++;
                end
                if (r_pend) begin
                    if (r_cnt >= r_dly) begin
                        m_axi_rvalid = 1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp; r_pend = 0;
                    end else r_cnt++;
                end
                if (m_axi_awvalid) begin m_axi_awready = !aw_block && (aw_cnt >= aw_dly); aw_cnt++; end
                else begin m_axi_awready = 0; aw_cnt = 0; end
                if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_dly); w_cnt++; end
                else begin m_axi_wready = 0; w_cnt = 0; end
                if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin m_axi_arready = 0; ar_cnt = 0; end
                p_awv = m_axi_awvalid; p_wv = m_axi_wvalid; p_bready = m_axi_bready;
                p_arv = m_axi_arvalid; p_rready = m_axi_rready;
            end
        end
    end

    // Transaction-level model: which channel obligations are still open for the current command.
    bit          live = 0, m_busy = 0, m_aw = 0, m_w = 0, m_b = 0, m_ar = 0, m_r = 0, m_rsp = 0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic [1:0]  m_resp = '0;
    int          m_wd = 0;

    initial forever begin
        @(posedge clk100);
        if (rst) begin
            live = 1; {m_busy, m_aw, m_w, m_b, m_ar, m_r, m_rsp} = '0; m_wd = 0;
        end else if (live) begin
            if (m_aw || m_w || m_b || m_ar || m_r) m_wd++;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1; m_addr = cmd_addr; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
                    m_aw = cmd_write; m_w = cmd_write; m_ar = !cmd_write; m_wd = 0;
                end
            end else begin
                if (m_rsp && rsp_ready) begin m_rsp = 0; m_busy = 0; end
                if (m_b && m_axi_bvalid) begin m_b = 0; m_rsp = 1; m_rdata = 0; m_resp = m_axi_bresp; end
                if (m_r && m_axi_rvalid) begin
                    m_r = 0; m_rsp = 1; m_rdata = m_axi_rdata; m_resp = m_axi_rresp;
                end
                if (m_ar && m_axi_arready) begin m_ar = 0; m_r = 1; end
                if (m_aw || m_w) begin
                    if (m_aw && m_axi_awready) m_aw = 0;
                    if (m_w && m_axi_wready) m_w = 0;
                    if (!m_aw && !m_w) m_b = 1;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial forever begin
        @(negedge clk100);
        if (live) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            chk("busy_o", 32'(busy_o), 32'(m_busy));
            chk("awvalid", 32'(m_axi_awvalid), 32'(m_aw));
            chk("wvalid", 32'(m_axi_wvalid), 32'(m_w));
            chk("bready", 32'(m_axi_bready), 32'(m_b));
            chk("arvalid", 32'(m_axi_arvalid), 32'(m_ar));
            chk("rready", 32'(m_axi_rready), 32'(m_r));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            chk("timeout_o", 32'(timeout_o), 32'(m_wd >= TO));
            chk("awprot", 32'(m_axi_awprot), 32'h0);
            chk("arprot", 32'(m_axi_arprot), 32'h0);
            if (m_rsp) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_resp", 32'(rsp_resp), 32'(m_resp));
            end
            if (m_aw) chk("awaddr", 32'(m_axi_awaddr), 32'(m_addr));
            if (m_ar) chk("araddr", 32'(m_axi_araddr), 32'(m_addr));
            if (m_w) begin
                chk("wdata", m_axi_wdata, m_wdata);
                chk("wstrb", 32'(m_axi_wstrb), 32'(m_wstrb));
            end
        end
    end

    // Presents a command at a falling edge; returns at the falling edge of cycle N+1.
    task automatic issue(input bit wr, input logic [8:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int n = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk100); n++; end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(negedge clk100);
        cmd_valid = 0; cmd_addr = 9'h1FF; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'h0;
    endtask

    task automatic take_rsp(input int hold, input logic [31:0] er, input logic [1:0] eresp);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk100); n++; end
        chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata_lit", rsp_rdata, er);
        chk("rsp_resp_lit", 32'(rsp_resp), 32'(eresp));
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 0;
            @(negedge clk100);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, er);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1;
        @(negedge clk100);
        rsp_ready = 0;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish, got running, expected done");
        $fatal(1, "bench stuck");
    end

    initial begin
        int b0;
        int n;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        repeat (3) @(negedge clk100);
        rst = 0;
        @(negedge clk100);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'd0);
        chk("rst_readies", 32'({m_axi_bready, m_axi_rready}), 32'd0);

        // Zero-wait write.
        issue(1, 9'h000, 32'h0000_0005, 4'hF);
        chk("zw_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("zw_awaddr", 32'(m_axi_awaddr), 32'd0);
        chk("zw_wdata", m_axi_wdata, 32'h5);
        @(negedge clk100);
        chk("zw_bready", 32'(m_axi_bready), 32'd1);
        @(negedge clk100);
        chk("zw_rsp_valid", 32'(rsp_valid), 32'd1);
        take_rsp(0, 32'h0, 2'b00);

        // Skewed write: aw first, then w first.
        aw_dly = 0; w_dly = 3; cfg_bresp = 2'b10; b0 = b_count;
        issue(1, 9'h0C4, 32'h1357_9BDF, 4'h3);
        @(negedge clk100);
        chk("skew1_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("skew1_wvalid", 32'(m_axi_wvalid), 32'd1);
        take_rsp(0, 32'h0, 2'b10);
        chk("skew1_bcount", 32'(b_count - b0), 32'd1);
        aw_dly = 3; w_dly = 0; cfg_bresp = 2'b01; b0 = b_count;
        issue(1, 9'h104, 32'h2468_ACE0, 4'hC);
        @(negedge clk100);
        chk("skew2_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("skew2_wvalid", 32'(m_axi_wvalid), 32'd0);
        take_rsp(0, 32'h0, 2'b01);
        chk("skew2_bcount", 32'(b_count - b0), 32'd1);
        aw_dly = 0; w_dly = 0; cfg_bresp = 2'b00;

        // Read with wait states.
        ar_dly = 2; r_dly = 4; cfg_rdata = 32'h0000_00A5; cfg_rresp = 2'b00;
        issue(0, 9'h008, 32'h0, 4'h0);
        chk("rd_arvalid", 32'(m_axi_arvalid), 32'd1);
        chk("rd_araddr", 32'(m_axi_araddr), 32'h8);
        take_rsp(0, 32'hA5, 2'b00);

        // Response backpressure.
        ar_dly = 0; r_dly = 0; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
        issue(0, 9'h010, 32'h0, 4'h0);
        take_rsp(5, 32'h1234_5678, 2'b10);

        // Watchdog with a stalled write address channel.
        aw_block = 1;
        issue(1, 9'h004, 32'h0000_000A, 4'hF);
        for (int k = 1; k <= 17; k++) begin
            if (k == 16) chk("wd_not_yet", 32'(timeout_o), 32'd0);
            if (k == 17) begin
                chk("wd_timeout", 32'(timeout_o), 32'd1);
                chk("wd_awvalid", 32'(m_axi_awvalid), 32'd1);
            end
            if (k < 17) @(negedge clk100);
        end
        aw_block = 0;
        take_rsp(0, 32'h0, 2'b00);
        chk("wd_sticky", 32'(timeout_o), 32'd1);
        cfg_rdata = 32'h0000_0042; cfg_rresp = 2'b00;
        issue(0, 9'h00C, 32'h0, 4'h0);
        chk("wd_cleared", 32'(timeout_o), 32'd0);
        take_rsp(0, 32'h42, 2'b00);

        // Reset while waiting for read data.
        r_dly = 10;
        issue(0, 9'h018, 32'h0, 4'h0);
        n = 0;
        while (m_axi_rready !== 1'b1 && n < 50) begin @(negedge clk100); n++; end
        chk("mr_rready_seen", 32'(m_axi_rready), 32'd1);
        rst = 1;
        @(negedge clk100);
        chk("mr_rready", 32'(m_axi_rready), 32'd0);
        chk("mr_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready}), 32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk100);
        rst = 0;
        repeat (15) @(negedge clk100);
        chk("mr_no_rsp", 32'(rsp_valid), 32'd0);

        // Recovery: plain zero-wait read.
        r_dly = 0; cfg_rdata = 32'hCAFE_0001; cfg_rresp = 2'b00;
        issue(0, 9'h020, 32'h0, 4'h0);
        take_rsp(0, 32'hCAFE_0001, 2'b00);

        repeat (3) @(negedge clk100);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
